// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile: oversampling I2C target answering NUM_DEV consecutive
// addresses, each backed by its own register bank with a persistent pointer.
// A host port preloads and inspects the banks; optional SCL stretching before
// every read byte.
module i2c_target_regfile #(
  parameter int                        I2C_ADDR_WIDTH = 7,
  parameter int                        I2C_DATA_WIDTH = 8,
  parameter logic [I2C_ADDR_WIDTH-1:0] BASE_ADDR      = 7'h22,
  parameter int                        NUM_DEV        = 2,
  parameter int                        REG_DEPTH      = 16,
  parameter int                        SYNC_STAGES    = 2,
  parameter int                        STRETCH_CYCLES = 0,
  localparam int                       PW             = $clog2(REG_DEPTH),
  localparam int                       DW             = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      scl_oe_o,
  output logic                      sda_oe_o,
  input  logic                      host_we_i,
  input  logic [DW-1:0]             host_dev_i,
  input  logic [PW-1:0]             host_addr_i,
  input  logic [I2C_DATA_WIDTH-1:0] host_wdata_i,
  output logic [I2C_DATA_WIDTH-1:0] host_rdata_o,
  output logic                      busy_o,
  output logic                      xfer_done_o,
  output logic [DW-1:0]             xfer_dev_o,
  output logic                      xfer_op_o,
  output logic [7:0]                xfer_len_o
);

  localparam int SHW = (I2C_ADDR_WIDTH + 1 > I2C_DATA_WIDTH) ? I2C_ADDR_WIDTH + 1 : I2C_DATA_WIDTH;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_ADDR     = 4'd1;
  localparam logic [3:0] S_ADDR_ACK = 4'd2;
  localparam logic [3:0] S_PTR      = 4'd3;
  localparam logic [3:0] S_WR_BYTE  = 4'd4;
  localparam logic [3:0] S_WR_ACK   = 4'd5;
  localparam logic [3:0] S_STRETCH  = 4'd6;
  localparam logic [3:0] S_RD_BYTE  = 4'd7;
  localparam logic [3:0] S_RD_ACK   = 4'd8;
  localparam logic [3:0] S_IGNORE   = 4'd9;

  localparam logic [4:0]  ADDR_LAST = 5'(I2C_ADDR_WIDTH);
  localparam logic [4:0]  DATA_LAST = 5'(I2C_DATA_WIDTH - 1);
  localparam logic [4:0]  DATA_BITS = 5'(I2C_DATA_WIDTH);
  localparam logic [15:0] ST_LAST   = 16'(STRETCH_CYCLES - 1);
  localparam logic [I2C_ADDR_WIDTH-1:0] NDEV_A = I2C_ADDR_WIDTH'(NUM_DEV);

  typedef struct packed {
    logic                      we;
    logic [DW-1:0]             dev;
    logic [PW-1:0]             addr;
    logic [I2C_DATA_WIDTH-1:0] data;
  } wr_req_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_q, sda_q;
  logic scl_rise, scl_fall, start_det, stop_det;

  logic [3:0]                state;
  logic [4:0]                bit_cnt;
  logic [SHW-1:0]            shreg, shin;
  logic [DW-1:0]             dev_idx;
  logic                      rw, ack_ph, active;
  logic [7:0]                len, len_inc;
  logic [I2C_DATA_WIDTH-1:0] tx_sh, rd_byte;
  logic [15:0]               st_cnt;
  logic [NUM_DEV-1:0][PW-1:0] ptr;
  logic [NUM_DEV-1:0][REG_DEPTH-1:0][I2C_DATA_WIDTH-1:0] bank;

  logic [I2C_ADDR_WIDTH-1:0] addr_off;
  logic                      addr_hit;
  wr_req_t                   i2c_wr, host_wr;

  // Bring the bus lines into the clock domain; idle bus level is high.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

  assign shin     = {shreg[SHW-2:0], sda_s};
  assign addr_off = shin[I2C_ADDR_WIDTH:1] - BASE_ADDR;
  assign addr_hit = addr_off < NDEV_A;
  assign len_inc  = (len == 8'hFF) ? len : len + 8'd1;
  assign rd_byte  = bank[dev_idx][ptr[dev_idx]];

  // Bank write requests: the I2C side commits on the last data-bit rise.
  always_comb begin
    i2c_wr = '0;
    if (state == S_WR_BYTE && scl_rise && bit_cnt == DATA_LAST) begin
      i2c_wr.we   = 1'b1;
      i2c_wr.dev  = dev_idx;
      i2c_wr.addr = ptr[dev_idx];
      i2c_wr.data = shin[I2C_DATA_WIDTH-1:0];
    end
    host_wr.we   = host_we_i;
    host_wr.dev  = host_dev_i;
    host_wr.addr = host_addr_i;
    host_wr.data = host_wdata_i;
  end

  // Register banks; an I2C write shadows a host write to the same entry.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bank <= '0;
    end else begin
      for (int d = 0; d < NUM_DEV; d++) begin
        for (int e = 0; e < REG_DEPTH; e++) begin
          if (i2c_wr.we && i2c_wr.dev == DW'(d) && i2c_wr.addr == PW'(e))
            bank[d][e] <= i2c_wr.data;
          else if (host_wr.we && host_wr.dev == DW'(d) && host_wr.addr == PW'(e))
            bank[d][e] <= host_wr.data;
        end
      end
    end
  end

  // Registered host read port; out-of-range bank selects read as zero.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      host_rdata_o <= '0;
    else if ({1'b0, host_dev_i} < (DW+1)'(NUM_DEV))
      host_rdata_o <= bank[host_dev_i][host_addr_i];
    else
      host_rdata_o <= '0;
  end

  // Protocol FSM: START/STOP override everything, otherwise act on SCL edges.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= S_IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      dev_idx     <= '0;
      rw          <= 1'b0;
      ack_ph      <= 1'b0;
      active      <= 1'b0;
      len         <= '0;
      tx_sh       <= '0;
      st_cnt      <= '0;
      ptr         <= '0;
      sda_oe_o    <= 1'b0;
      scl_oe_o    <= 1'b0;
      busy_o      <= 1'b0;
      xfer_done_o <= 1'b0;
      xfer_dev_o  <= '0;
      xfer_op_o   <= 1'b0;
      xfer_len_o  <= '0;
    end else begin
      xfer_done_o <= 1'b0;
      if (start_det || stop_det) begin
        if (active) begin
          xfer_done_o <= 1'b1;
          xfer_dev_o  <= dev_idx;
          xfer_op_o   <= rw;
          xfer_len_o  <= len;
        end
        active   <= 1'b0;
        sda_oe_o <= 1'b0;
        scl_oe_o <= 1'b0;
        ack_ph   <= 1'b0;
        bit_cnt  <= '0;
        len      <= '0;
        busy_o   <= start_det;
        state    <= start_det ? S_ADDR : S_IDLE;
      end else begin
        case (state)
          S_ADDR: if (scl_rise) begin
            shreg   <= shin;
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == ADDR_LAST) begin
              bit_cnt <= '0;
              rw      <= shin[0];
              if (addr_hit) begin
                dev_idx <= addr_off[DW-1:0];
                active  <= 1'b1;
                state   <= S_ADDR_ACK;
              end else begin
                state   <= S_IGNORE;
              end
            end
          end
          // ACK slot spans one full SCL low/high period: fall to fall.
          S_ADDR_ACK, S_WR_ACK: if (scl_fall) begin
            if (!ack_ph) begin
              ack_ph   <= 1'b1;
              sda_oe_o <= 1'b1;
            end else begin
              ack_ph   <= 1'b0;
              sda_oe_o <= 1'b0;
              if (state == S_WR_ACK) begin
                state <= S_WR_BYTE;
              end else if (!rw) begin
                state <= S_PTR;
              end else if (STRETCH_CYCLES > 0) begin
                scl_oe_o <= 1'b1;
                st_cnt   <= '0;
                state    <= S_STRETCH;
              end else begin
                sda_oe_o <= ~rd_byte[I2C_DATA_WIDTH-1];
                tx_sh    <= rd_byte << 1;
                bit_cnt  <= 5'd1;
                state    <= S_RD_BYTE;
              end
            end
          end
          S_PTR, S_WR_BYTE: if (scl_rise) begin
            shreg   <= shin;
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= S_WR_ACK;
              if (state == S_PTR) begin
                ptr[dev_idx] <= shin[PW-1:0];
              end else begin
                ptr[dev_idx] <= ptr[dev_idx] + PW'(1);
                len          <= len_inc;
              end
            end
          end
          // SCL is held low here, so the first data bit may be driven on exit.
          S_STRETCH: begin
            st_cnt <= st_cnt + 16'd1;
            if (st_cnt == ST_LAST) begin
              scl_oe_o <= 1'b0;
              sda_oe_o <= ~rd_byte[I2C_DATA_WIDTH-1];
              tx_sh    <= rd_byte << 1;
              bit_cnt  <= 5'd1;
              state    <= S_RD_BYTE;
            end
          end
          S_RD_BYTE: if (scl_fall) begin
            if (bit_cnt == DATA_BITS) begin
              sda_oe_o <= 1'b0;
              bit_cnt  <= '0;
              ack_ph   <= 1'b0;
              state    <= S_RD_ACK;
            end else begin
              sda_oe_o <= ~tx_sh[I2C_DATA_WIDTH-1];
              tx_sh    <= tx_sh << 1;
              bit_cnt  <= bit_cnt + 5'd1;
            end
          end
          // Master ACK continues the burst on the next fall; NACK ends it.
          S_RD_ACK: begin
            if (scl_rise) begin
              ptr[dev_idx] <= ptr[dev_idx] + PW'(1);
              len          <= len_inc;
              if (sda_s) state  <= S_IGNORE;
              else       ack_ph <= 1'b1;
            end else if (scl_fall && ack_ph) begin
              ack_ph <= 1'b0;
              if (STRETCH_CYCLES > 0) begin
                scl_oe_o <= 1'b1;
                st_cnt   <= '0;
                state    <= S_STRETCH;
              end else begin
                sda_oe_o <= ~rd_byte[I2C_DATA_WIDTH-1];
                tx_sh    <= rd_byte << 1;
                bit_cnt  <= 5'd1;
                state    <= S_RD_BYTE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
